mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM pipeline register. It turns each load or store presented by that register into a sequence of byte transactions on the memory-controller port. It stalls the upstream pipeline while the access is in flight. It then hands a write-back result to the MEM/WB register, with sign or zero extension applied to loads.

---
 rtl/mem_stage_pkg.sv | 62 ++++++
 rtl/mem_load_ext.sv | 22 ++
 rtl/mem_stage.sv | 152 +++++++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, op encodings,
// FSM state encoding and per-op decode helpers.
package mem_stage_pkg;

   localparam int unsigned RegLen     = 32;
   localparam int unsigned RegAddrLen = 5;
   localparam int unsigned AddrLen    = 32;
   localparam int unsigned OpLen      = 4;

   typedef logic [OpLen-1:0] op_t;

   // Any code outside OpLb..OpSw is a non-memory op; OpAlu is one such code.
   localparam op_t OpAlu = 4'd0;
   localparam op_t OpLb  = 4'd1;
   localparam op_t OpLh  = 4'd2;
   localparam op_t OpLw  = 4'd3;
   localparam op_t OpLbu = 4'd4;
   localparam op_t OpLhu = 4'd5;
   localparam op_t OpSb  = 4'd6;
   localparam op_t OpSh  = 4'd7;
   localparam op_t OpSw  = 4'd8;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } state_e;

   function automatic logic is_load(input op_t op);
      return (op == OpLb) || (op == OpLh) || (op == OpLw) || (op == OpLbu) || (op == OpLhu);
   endfunction

   function automatic logic is_store(input op_t op);
      return (op == OpSb) || (op == OpSh) || (op == OpSw);
   endfunction

   function automatic logic is_mem(input op_t op);
      return is_load(op) || is_store(op);
   endfunction

   // Index of the final byte of the access (byte count minus one).
   function automatic logic [1:0] last_byte(input op_t op);
      logic [1:0] r;
      case (op)
         OpLh, OpLhu, OpSh: r = 2'd1;
         OpLw, OpSw:        r = 2'd3;
         default:           r = 2'd0;
      endcase
      return r;
   endfunction

   function automatic logic is_misaligned(input op_t op, input logic [1:0] addr_lo);
      logic r;
      case (op)
         OpLh, OpLhu, OpSh: r = addr_lo[0];
         OpLw, OpSw:        r = (addr_lo != 2'b00);
         default:           r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the assembled little-endian load buffer by op.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  op_t         op,
   input  logic [31:0] load_buf,
   output logic [31:0] load_val
);

   // Select the extension for the loaded width.
   always_comb begin
      load_val = load_buf;
      case (op)
         OpLb:    load_val = {{24{load_buf[7]}}, load_buf[7:0]};
         OpLh:    load_val = {{16{load_buf[15]}}, load_buf[15:0]};
         OpLbu:   load_val = {24'h0, load_buf[7:0]};
         OpLhu:   load_val = {16'h0, load_buf[15:0]};
         default: load_val = load_buf;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: breaks loads/stores into byte transactions on
// the memory-controller port, stalls upstream meanwhile, and presents a
// one-cycle write-back result.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned H/W accesses are rejected
// without touching memory and flagged on mem_misalign.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  ex_mem_rdy,
   input  logic [RegLen-1:0]     mem_rd_data,
   input  logic [RegAddrLen-1:0] mem_rd_addr,
   input  logic [AddrLen-1:0]    mem_addr_i,
   input  op_t                   mem_op,
   output logic                  mctl_req,
   output logic                  mctl_we,
   output logic [AddrLen-1:0]    mctl_addr,
   output logic [7:0]            mctl_wdata,
   input  logic [7:0]            mctl_rdata,
   input  logic                  mctl_done,
   output logic                  stall_req,
   output logic                  wb_valid,
   output logic                  wb_we,
   output logic [RegAddrLen-1:0] wb_rd_addr,
`ifdef MEM_ALIGN_CHECK_EN
   output logic                  mem_misalign,
`endif
   output logic [RegLen-1:0]     wb_rd_data
);

   state_e                  state_q, state_d;
   op_t                     op_q, op_d;
   logic [AddrLen-1:0]      addr_q, addr_d;
   logic [RegLen-1:0]       data_q, data_d;
   logic [RegAddrLen-1:0]   rd_q, rd_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [1:0]              last_q, last_d;
   logic [31:0]             lbuf_q, lbuf_d;
   logic                    misalign_q, misalign_d;
   logic                    misalign_in;
   logic [31:0]             load_val;
   logic                    in_idle, in_access, in_done;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_in = is_misaligned(mem_op, mem_addr_i[1:0]);
`else
   assign misalign_in = 1'b0;
`endif

   assign in_idle   = (state_q == StIdle);
   assign in_access = (state_q == StAccess);
   assign in_done   = (state_q == StDone);

   mem_load_ext u_load_ext (
      .op       (op_q),
      .load_buf (lbuf_q),
      .load_val (load_val)
   );

   // Next-state logic: accept in IDLE, step the byte loop in ACCESS.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      lbuf_d     = lbuf_q;
      misalign_d = misalign_q;
      case (state_q)
         StIdle: begin
            if (ex_mem_rdy) begin
               op_d       = mem_op;
               addr_d     = mem_addr_i;
               data_d     = mem_rd_data;
               rd_d       = mem_rd_addr;
               cnt_d      = 2'd0;
               last_d     = last_byte(mem_op);
               lbuf_d     = 32'h0;
               misalign_d = misalign_in;
               state_d    = (is_mem(mem_op) && !misalign_in) ? StAccess : StDone;
            end
         end
         StAccess: begin
            if (mctl_done) begin
               if (is_load(op_q)) begin
                  lbuf_d[{cnt_q, 3'b000} +: 8] = mctl_rdata;
               end
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == last_q) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register; rdy low freezes everything, including the byte counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         op_q       <= OpAlu;
         addr_q     <= '0;
         data_q     <= '0;
         rd_q       <= '0;
         cnt_q      <= 2'd0;
         last_q     <= 2'd0;
         lbuf_q     <= 32'h0;
         misalign_q <= 1'b0;
      end else if (rdy) begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         lbuf_q     <= lbuf_d;
         misalign_q <= misalign_d;
      end
   end

   // Outputs decode from registered state, so reset clears them asynchronously.
   always_comb begin
      mctl_req   = in_access;
      mctl_we    = in_access && is_store(op_q);
      mctl_addr  = in_access ? (addr_q + {30'h0, cnt_q}) : '0;
      mctl_wdata = in_access ? data_q[{cnt_q, 3'b000} +: 8] : 8'h0;
      stall_req  = (in_idle && ex_mem_rdy && is_mem(mem_op) && !misalign_in) || in_access;
      wb_valid   = in_done;
      wb_we      = in_done && !misalign_q && !is_store(op_q) && (rd_q != '0);
      wb_rd_addr = in_done ? rd_q : '0;
      wb_rd_data = in_done ? (is_load(op_q) ? load_val : data_q) : '0;
   end

`ifdef MEM_ALIGN_CHECK_EN
   // Misalign flag accompanies the write-back pulse only.
   always_comb begin
      mem_misalign = in_done && misalign_q;
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage with a simple byte-level
// memory-controller responder and hand sequences for rdy stalls and reset.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, ex_mem_rdy;
   logic [31:0] mem_rd_data;
   logic [4:0]  mem_rd_addr;
   logic [31:0] mem_addr_i;
   op_t         mem_op;
   logic        mctl_req, mctl_we;
   logic [31:0] mctl_addr;
   logic [7:0]  mctl_wdata, mctl_rdata;
   logic        mctl_done;
   logic        stall_req, wb_valid, wb_we;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_data;
`ifdef MEM_ALIGN_CHECK_EN
   logic        mem_misalign;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .ex_mem_rdy  (ex_mem_rdy),
      .mem_rd_data (mem_rd_data),
      .mem_rd_addr (mem_rd_addr),
      .mem_addr_i  (mem_addr_i),
      .mem_op      (mem_op),
      .mctl_req    (mctl_req),
      .mctl_we     (mctl_we),
      .mctl_addr   (mctl_addr),
      .mctl_wdata  (mctl_wdata),
      .mctl_rdata  (mctl_rdata),
      .mctl_done   (mctl_done),
      .stall_req   (stall_req),
      .wb_valid    (wb_valid),
      .wb_we       (wb_we),
      .wb_rd_addr  (wb_rd_addr),
`ifdef MEM_ALIGN_CHECK_EN
      .mem_misalign(mem_misalign),
`endif
      .wb_rd_data  (wb_rd_data)
   );

   typedef struct {
      op_t         op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  rd;
      logic [31:0] rbytes;    // bytes returned by controller, byte 0 in [7:0]
      int          delay;     // idle cycles before each done
      logic        is_st;
      logic [31:0] exp_w;     // expected write bytes, byte 0 in [7:0]
      logic        exp_stall; // stall_req in the accept cycle
      logic        chk_data;
      logic [31:0] exp_data;
      logic        exp_we;
      int          exp_n;     // bytes transferred
      int          exp_cyc;   // cycles from first sample to wb_valid
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int nb;
      int cyc;
      int wt;
      @(negedge clk);
      mem_op      = v.op;
      mem_addr_i  = v.addr;
      mem_rd_data = v.data;
      mem_rd_addr = v.rd;
      ex_mem_rdy  = 1'b1;
      mctl_done   = 1'b0;
      #1 check($sformatf("v%0d stall_accept", idx), {31'h0, stall_req}, {31'h0, v.exp_stall});
      @(negedge clk);
      ex_mem_rdy = 1'b0;
      nb = 0;
      cyc = 0;
      wt = 0;
      while (!wb_valid && cyc < 64) begin
         mctl_done = 1'b0;
         if (mctl_req) begin
            if (wt == v.delay) begin
               check($sformatf("v%0d addr%0d", idx, nb), mctl_addr, v.addr + 32'(nb));
               check($sformatf("v%0d we%0d", idx, nb), {31'h0, mctl_we}, {31'h0, v.is_st});
               if (v.is_st) begin
                  check($sformatf("v%0d wdata%0d", idx, nb), {24'h0, mctl_wdata},
                        {24'h0, v.exp_w[8*(nb & 3) +: 8]});
               end
               check($sformatf("v%0d stall_busy%0d", idx, nb), {31'h0, stall_req}, 32'h1);
               mctl_rdata = v.rbytes[8*(nb & 3) +: 8];
               mctl_done  = 1'b1;
               nb++;
               wt = 0;
            end else begin
               wt++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      mctl_done = 1'b0;
      check($sformatf("v%0d wb_valid", idx), {31'h0, wb_valid}, 32'h1);
      check($sformatf("v%0d wb_we", idx), {31'h0, wb_we}, {31'h0, v.exp_we});
      check($sformatf("v%0d wb_rd_addr", idx), {27'h0, wb_rd_addr}, {27'h0, v.rd});
      if (v.chk_data) begin
         check($sformatf("v%0d wb_rd_data", idx), wb_rd_data, v.exp_data);
      end
      check($sformatf("v%0d nbytes", idx), 32'(nb), 32'(v.exp_n));
      check($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.exp_cyc));
      check($sformatf("v%0d stall_done", idx), {31'h0, stall_req}, 32'h0);
      check($sformatf("v%0d req_done", idx), {31'h0, mctl_req}, 32'h0);
      @(negedge clk);
      check($sformatf("v%0d wb_pulse_end", idx), {31'h0, wb_valid}, 32'h0);
   endtask

   initial begin
      logic [31:0] log_addr[$];
      logic [7:0]  log_data[$];
      logic [31:0] sw_exp;
      int          k;
      int          seen_wb;
      int          nreads;

      rst = 1'b0; rdy = 1'b1; ex_mem_rdy = 1'b0;
      mem_rd_data = '0; mem_rd_addr = '0; mem_addr_i = '0; mem_op = OpAlu;
      mctl_rdata = '0; mctl_done = 1'b0;

      //              op     addr          data          rd     rbytes        dly st exp_w        stl chk exp_data      we n cyc
      vecs.push_back('{OpAlu, 32'h0,        32'h00001234, 5'd5,  32'h0,        0, 0, 32'h0,       0, 1, 32'h00001234, 1, 0, 0});
      vecs.push_back('{OpLw,  32'h00000100, 32'h0,        5'd3,  32'h12345678, 0, 0, 32'h0,       1, 1, 32'h12345678, 1, 4, 4});
      vecs.push_back('{OpLb,  32'h00000007, 32'h0,        5'd7,  32'h00000080, 0, 0, 32'h0,       1, 1, 32'hFFFFFF80, 1, 1, 1});
      vecs.push_back('{OpLbu, 32'h00000007, 32'h0,        5'd7,  32'h00000080, 0, 0, 32'h0,       1, 1, 32'h00000080, 1, 1, 1});
      vecs.push_back('{OpSh,  32'h00000020, 32'h0000ABCD, 5'd4,  32'h0,        3, 1, 32'h0000ABCD, 1, 0, 32'h0,       0, 2, 8});
      vecs.push_back('{OpLh,  32'h000001FE, 32'h0,        5'd2,  32'h00009234, 0, 0, 32'h0,       1, 1, 32'hFFFF9234, 1, 2, 2});
      vecs.push_back('{OpLhu, 32'h000001FE, 32'h0,        5'd2,  32'h00009234, 0, 0, 32'h0,       1, 1, 32'h00009234, 1, 2, 2});
      vecs.push_back('{OpAlu, 32'h0,        32'hDEADBEEF, 5'd0,  32'h0,        0, 0, 32'h0,       0, 1, 32'hDEADBEEF, 0, 0, 0});
      vecs.push_back('{OpSb,  32'h00000055, 32'h000000A5, 5'd9,  32'h0,        0, 1, 32'h000000A5, 1, 0, 32'h0,       0, 1, 1});
      vecs.push_back('{OpLw,  32'h00000040, 32'h0,        5'd31, 32'hDEADBEEF, 1, 0, 32'h0,       1, 1, 32'hDEADBEEF, 1, 4, 8});
      vecs.push_back('{OpLb,  32'h00000011, 32'h0,        5'd0,  32'h0000007F, 0, 0, 32'h0,       1, 1, 32'h0000007F, 0, 1, 1});
`ifndef MEM_ALIGN_CHECK_EN
      // Halfword straddling the top of the address space wraps to 0.
      vecs.push_back('{OpLh,  32'hFFFFFFFF, 32'h0,        5'd6,  32'h00008001, 0, 0, 32'h0,       1, 1, 32'hFFFF8001, 1, 2, 2});
`endif

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst mctl_req", {31'h0, mctl_req}, 32'h0);
      check("rst mctl_we", {31'h0, mctl_we}, 32'h0);
      check("rst mctl_addr", mctl_addr, 32'h0);
      check("rst mctl_wdata", {24'h0, mctl_wdata}, 32'h0);
      check("rst stall_req", {31'h0, stall_req}, 32'h0);
      check("rst wb_valid", {31'h0, wb_valid}, 32'h0);
      check("rst wb_we", {31'h0, wb_we}, 32'h0);
      check("rst wb_rd_addr", {27'h0, wb_rd_addr}, 32'h0);
      check("rst wb_rd_data", wb_rd_data, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
      check("rst mem_misalign", {31'h0, mem_misalign}, 32'h0);
`endif
      rst = 1'b1;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // SW with rdy dropping mid-access and a stray ex_mem_rdy while busy.
      sw_exp = 32'h11223344;
      @(negedge clk);
      mem_op = OpSw; mem_addr_i = 32'h00000200; mem_rd_data = sw_exp; mem_rd_addr = 5'd8;
      ex_mem_rdy = 1'b1;
      @(negedge clk);
      ex_mem_rdy = 1'b0;
      k = 0;
      while (!wb_valid && k < 40) begin
         rdy = !(k == 1 || k == 2 || k == 5);
         ex_mem_rdy = (k == 3);
         mem_op = (k == 3) ? OpAlu : OpSw;
         mctl_done = mctl_req;
         if (!rdy) check($sformatf("sw stall_hold k%0d", k), {31'h0, stall_req}, 32'h1);
         if (mctl_req && rdy) begin
            log_addr.push_back(mctl_addr);
            log_data.push_back(mctl_wdata);
         end
         @(negedge clk);
         k++;
      end
      rdy = 1'b1; mctl_done = 1'b0; ex_mem_rdy = 1'b0;
      check("sw wb_valid", {31'h0, wb_valid}, 32'h1);
      check("sw wb_we", {31'h0, wb_we}, 32'h0);
      check("sw nbytes", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
         check($sformatf("sw addr%0d", i), log_addr[i], 32'h00000200 + 32'(i));
         check($sformatf("sw data%0d", i), {24'h0, log_data[i]}, {24'h0, sw_exp[8*i +: 8]});
      end
      @(negedge clk);

      // LW interrupted by reset while byte 2 is being requested.
      mem_op = OpLw; mem_addr_i = 32'h00000300; mem_rd_addr = 5'd10;
      ex_mem_rdy = 1'b1;
      @(negedge clk);
      ex_mem_rdy = 1'b0;
      k = 0;
      nreads = 0;
      while (!(mctl_req && mctl_addr == 32'h00000302) && k < 20) begin
         mctl_done = mctl_req;
         mctl_rdata = 8'h5A;
         if (mctl_req) nreads++;
         @(negedge clk);
         k++;
      end
      check("lw_rst reached byte2", 32'(nreads), 32'd2);
      mctl_done = 1'b1;
      #2 rst = 1'b0;
      #1 check("lw_rst req_async", {31'h0, mctl_req}, 32'h0);
      check("lw_rst stall_async", {31'h0, stall_req}, 32'h0);
      mctl_done = 1'b0;
      seen_wb = 0;
      repeat (2) begin
         @(negedge clk);
         if (wb_valid) seen_wb++;
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (wb_valid || mctl_req) seen_wb++;
      end
      check("lw_rst no_wb", 32'(seen_wb), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
      // Misaligned LW is rejected without a memory request.
      @(negedge clk);
      mem_op = OpLw; mem_addr_i = 32'h00000102; mem_rd_addr = 5'd12;
      ex_mem_rdy = 1'b1;
      #1 check("mis stall_accept", {31'h0, stall_req}, 32'h0);
      @(negedge clk);
      ex_mem_rdy = 1'b0;
      check("mis req", {31'h0, mctl_req}, 32'h0);
      check("mis wb_valid", {31'h0, wb_valid}, 32'h1);
      check("mis flag", {31'h0, mem_misalign}, 32'h1);
      check("mis wb_we", {31'h0, wb_we}, 32'h0);
      @(negedge clk);
      check("mis flag_end", {31'h0, mem_misalign}, 32'h0);
      check("mis req_after", {31'h0, mctl_req}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
